// File: rtl/mem_copy_ctrl.sv
// mem_copy_ctrl: copies a block of ROM_D words into RAM_B, verifies it
// word-for-word, and hands the RAM port to the display scan while idle.
module mem_copy_ctrl #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 32,
  parameter int unsigned COUNT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic          scan_grant,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_addr,
  output logic [7:0]    err_count
);

  // Index register is one bit wider so COUNT = 2^AW is representable.
  localparam int unsigned IW   = AW + 1;
  localparam int unsigned CW   = 8;
  localparam logic [IW-1:0] LAST = IW'(COUNT - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY,
    S_VRD,
    S_VCMP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [AW-1:0]   base_q, base_d;
  logic            err_q, err_d;
  logic [AW-1:0]   err_addr_q, err_addr_d;
  logic [CW-1:0]   err_count_q, err_count_d;
  logic [AW-1:0]   cur_addr;

  // Run position wraps naturally modulo 2^AW.
  assign cur_addr = base_q + i_q[AW-1:0];

  // State and run registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      base_q      <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      base_q      <= base_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state, index stepping and mismatch bookkeeping.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    base_d      = base_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          base_d      = base;
          i_d         = '0;
          err_d       = 1'b0;
          err_addr_d  = '0;
          err_count_d = '0;
          state_d     = S_COPY;
        end
      end
      S_COPY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (i_q == LAST) begin
          i_d     = '0;
          state_d = S_VRD;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_VRD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_VCMP;
        end
      end
      S_VCMP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (ram_dout != rom_data) begin
            err_d = 1'b1;
            if (!err_q) begin
              err_addr_d = cur_addr;
            end
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CW'(1);
            end
          end
          if (i_q == LAST) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + IW'(1);
            state_d = S_VRD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Port decode from registered state; only IDLE exposes scan inputs directly.
  always_comb begin
    rom_addr   = cur_addr;
    ram_addr   = cur_addr;
    ram_we     = 1'b0;
    scan_grant = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rom_addr   = '0;
        ram_addr   = scan_addr;
        scan_grant = scan_req;
        busy       = 1'b0;
      end
      S_COPY: begin
        ram_we = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign ram_din   = rom_data;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// tb_mem_copy_ctrl: randomized self-checking bench with ROM/RAM models and
// a per-run reference of the expected write sequence and verify result.
module tb_mem_copy_ctrl;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned COUNT = 16;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] base;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          scan_grant;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] err_addr;
  logic [7:0]    err_count;

  mem_copy_ctrl #(.AW(AW), .DW(DW), .COUNT(COUNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base       (base),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .scan_req   (scan_req),
    .scan_addr  (scan_addr),
    .scan_grant (scan_grant),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_addr   (err_addr),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] rom [DEPTH];
  logic [DW-1:0] mem [DEPTH];
  bit            corrupt [DEPTH];
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  assign rom_data = rom[rom_addr];

  // Falling-edge RAM: write, plus registered read with optional readback corruption.
  always @(negedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_din);
    end
    ram_dout <= mem[ram_addr] ^ (corrupt[ram_addr] ? 32'h0000_5A5A : 32'h0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] b, input int k);
    return AW'((int'(b) + k) % DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_corrupt();
    for (int a = 0; a < DEPTH; a++) corrupt[a] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      64'(busy), 64'd0);
    check({tag, "_done"},      64'(done), 64'd0);
    check({tag, "_err"},       64'(err), 64'd0);
    check({tag, "_err_addr"},  64'(err_addr), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
    check({tag, "_ram_we"},    64'(ram_we), 64'd0);
    check({tag, "_rom_addr"},  64'(rom_addr), 64'd0);
    check({tag, "_grant"},     64'(scan_grant), 64'(scan_req));
    check({tag, "_ram_addr"},  64'(ram_addr), 64'(scan_addr));
  endtask

  // Full run: timing, arbitration, write sequence and verify result vs model.
  task automatic run_copy(input string tag, input logic [AW-1:0] b);
    int done_at   = -1;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int viol      = 0;
    int exp_cnt   = 0;
    bit exp_err   = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    wr_addr_q.delete();
    wr_data_q.delete();
    start = 1'b1;
    base  = b;
    tick();
    start = 1'b0;
    base  = AW'($urandom);
    for (int n = 0; n < 3 * COUNT + 20; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (busy && scan_grant) viol++;
      if (!busy) break;
      tick();
    end
    check({tag, "_done_cycle"}, 64'(done_at), 64'(3 * COUNT));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(3 * COUNT + 1));
    check({tag, "_grant_busy"}, 64'(viol), 64'd0);
    check({tag, "_grant_after"}, 64'(scan_grant), 64'(scan_req));
    check({tag, "_scan_addr"}, 64'(ram_addr), 64'(scan_addr));
    check({tag, "_nwrites"}, 64'(wr_addr_q.size()), 64'(COUNT));
    for (int k = 0; k < COUNT && k < wr_addr_q.size(); k++) begin
      check({tag, "_wr_addr"}, 64'(wr_addr_q[k]), 64'(addr_of(b, k)));
      check({tag, "_wr_data"}, 64'(wr_data_q[k]), 64'(rom[addr_of(b, k)]));
    end
    for (int k = 0; k < COUNT; k++) begin
      if (corrupt[addr_of(b, k)]) begin
        if (!exp_err) exp_addr = addr_of(b, k);
        exp_err = 1'b1;
        exp_cnt++;
      end
    end
    if (exp_cnt > 255) exp_cnt = 255;
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_err_addr"}, 64'(err_addr), 64'(exp_addr));
    check({tag, "_err_count"}, 64'(err_count), 64'(exp_cnt));
  endtask

  initial begin
    logic [AW-1:0] b;
    int dn;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    base      = '0;
    scan_req  = 1'b1;
    scan_addr = AW'($urandom);
    clear_corrupt();
    for (int a = 0; a < DEPTH; a++) begin
      rom[a] = DW'(a);
      mem[a] = '0;
    end
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Identity copy from base 0.
    run_copy("ident", AW'(0));

    // Readback corruption of words 5 and 9.
    corrupt[5] = 1'b1;
    corrupt[9] = 1'b1;
    tick();
    run_copy("corrupt", AW'(0));
    clear_corrupt();

    // Wrap past the top of the address space.
    for (int a = 0; a < DEPTH; a++) rom[a] = $urandom;
    scan_addr = AW'($urandom);
    tick();
    run_copy("wrap", AW'(10'h3F8));

    // Random bases, contents and corruption sets.
    for (int r = 0; r < 5; r++) begin
      clear_corrupt();
      for (int a = 0; a < DEPTH; a++) rom[a] = $urandom;
      b = AW'($urandom);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        corrupt[addr_of(b, int'($urandom_range(0, COUNT - 1)))] = 1'b1;
      scan_req  = 1'($urandom);
      scan_addr = AW'($urandom);
      tick();
      run_copy("rand", b);
    end
    clear_corrupt();
    scan_req = 1'b1;

    // Abort during VCMP of word 3; a start pulse mid-run must be ignored.
    b = AW'(10'h040);
    corrupt[addr_of(b, 1)] = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    tick();
    start = 1'b1;
    base  = b;
    tick();
    start = 1'b0;
    dn    = 0;
    for (int n = 0; n < COUNT + 8; n++) begin
      if (n == 3) begin
        start = 1'b1;
        base  = AW'(10'h100);
      end
      if (n == 4) start = 1'b0;
      if (n == COUNT + 7) begin
        check("abort_busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
      end
      if (done) dn++;
      tick();
    end
    abort = 1'b0;
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_grant", 64'(scan_grant), 64'd1);
    for (int n = 0; n < 5; n++) begin
      if (done) dn++;
      tick();
    end
    check("abort_no_done", 64'(dn), 64'd0);
    check("abort_err", 64'(err), 64'd1);
    check("abort_err_addr", 64'(err_addr), 64'(addr_of(b, 1)));
    check("abort_err_count", 64'(err_count), 64'd1);
    check("abort_nwrites", 64'(wr_addr_q.size()), 64'(COUNT));
    for (int k = 0; k < COUNT && k < wr_addr_q.size(); k++)
      check("abort_wr_addr", 64'(wr_addr_q[k]), 64'(addr_of(b, k)));
    clear_corrupt();

    // start with abort in IDLE: nothing starts, status untouched.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_idle", 64'(busy), 64'd0);
    tick();
    check("sa_idle2", 64'(busy), 64'd0);
    check("sa_err_kept", 64'(err_count), 64'd1);

    // Reset while idle clears sticky status.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_idle");

    // Reset mid-COPY at word 7, then a full run.
    tick();
    start = 1'b1;
    base  = AW'(10'h123);
    tick();
    start = 1'b0;
    for (int n = 0; n < 7; n++) tick();
    check("midcopy_we", 64'(ram_we), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_copy");
    run_copy("after_rst", AW'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_ctrl.md
# mem_copy_ctrl

Sequencer for the board's ROM_D / RAM_B pair. On a start pulse it copies a block of COUNT words from the distributed ROM into the single-port block RAM, then reads the block back and compares it word-for-word against the ROM. It reports done, error status, the first failing address and a mismatch count for the 8-channel display mux. When idle, it hands the RAM port to a display-scan requester.

## Interface
- AW, default 10: address width of ROM and RAM.
- DW, default 32: data width.
- COUNT, default 16: words per copy/verify run (1..2^AW).
- clk  in  1  system clock (clk_100mhz domain).
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that requests a run.
- abort  in  1  level that cancels a run in progress.
- base  in  AW  first address of the run, sampled with start.
- rom_addr  out  AW  address to ROM_D.
- rom_data  in  DW  ROM_D output, combinational from rom_addr.
- ram_addr  out  AW  address to RAM_B.
- ram_din  out  DW  write data to RAM_B.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DW  RAM_B read data, valid one clk after ram_addr is presented.
- scan_req  in  1  display scan wants the RAM port.
- scan_addr  in  AW  scan address.
- scan_grant  out  1  scan owns the RAM port this cycle.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at the end of a completed run.
- err  out  1  sticky: at least one mismatch in the last run.
- err_addr  out  AW  address of the first mismatch.
- err_count  out  8  mismatch count, saturating at 255.

## Operation
- States: IDLE, COPY, VRD, VCMP, DONE. The index register i (AW+1 bits) and a latched base register hold the run position.
- Current address is (base_q + i) mod 2^AW. Wrap past 2^AW-1 to 0 is legal and required.
- IDLE:
  - ram_addr = scan_addr, ram_we = 0, scan_grant = scan_req.
  - On start with abort = 0: latch base, i <= 0, clear err, err_addr and err_count, then go to COPY.
- COPY:
  - rom_addr = ram_addr = current address, ram_din = rom_data, ram_we = 1.
  - i increments each cycle.
  - After the write at i = COUNT-1: i <= 0, go to VRD.
- VRD: rom_addr = ram_addr = current address, ram_we = 0, then go to VCMP.
- VCMP:
  - Addresses are held. Compare ram_dout against rom_data.
  - On mismatch: err <= 1, err_count increments (saturating at 255), and err_addr is loaded only if err was 0.
  - If i = COUNT-1, go to DONE. Otherwise i increments and the state returns to VRD.
- DONE: done = 1 for this cycle only, then go to IDLE.
- scan_grant = 0 in every state except IDLE. The scan requester stalls and is never queued.
- Outside IDLE, start is ignored.
- abort in COPY, VRD or VCMP: go to IDLE on the next edge. No done pulse. err, err_addr and err_count keep their partial values. RAM contents already written remain.
- start and abort together in IDLE: abort wins and no run starts.
- busy = 1 in COPY, VRD, VCMP and DONE.
- All outputs decode from registered state. The only combinational input-to-output paths are the IDLE scan paths and ram_din = rom_data.

## Timing
- Reset values:
  - State IDLE, i = 0, base_q = 0.
  - busy, done, err, ram_we and scan_grant = 0 (scan_grant then follows scan_req in IDLE).
  - err_addr = 0, err_count = 0, rom_addr = 0.
- Cycle numbering: start is sampled at edge E0.
  - COPY occupies the cycles after E0 through E(COUNT-1). Words are written at E1 through E(COUNT).
  - VRD/VCMP pairs follow, 2 cycles per word.
  - done is high in the cycle after edge E(3·COUNT).
  - busy falls after E(3·COUNT+1). Total busy time is 3·COUNT+1 cycles.
- Reset mid-run overrides everything and returns all outputs to their reset values on the next edge.
- RAM_B is clocked on the falling edge by the top level. The controller relies only on "read data valid one rising edge after the address".

## Test plan
- Copy with COUNT = 16, base = 0x000, ROM = identity pattern, RAM model correct:
  - 16 writes, addr 0..15, data = ROM words.
  - done at cycle 49.
  - err = 0, err_count = 0.
- Verify mismatch: force the RAM model to corrupt words 5 and 9 on readback:
  - err = 1, err_addr = 5, err_count = 2, done still pulses.
- Wrap-around: base = 0x3F8, COUNT = 16:
  - write addresses 0x3F8..0x3FF, then 0x000..0x007.
  - no error.
- Arbitration: scan_req held high throughout:
  - scan_grant = 1 and ram_addr = scan_addr before start.
  - scan_grant = 0 while busy.
  - scan_grant = 1 again the cycle after done.
- Abort and retrigger:
  - abort during VCMP of word 3: IDLE next cycle, no done, counters frozen.
  - a start pulse during busy is ignored.
  - start and abort together in IDLE: stays IDLE.
- Reset mid-COPY at word 7: all outputs return to reset values next edge. A following start runs the full 49 cycles.
